systolic_input_feeder: RTL and testbench
========================================

# systolic_input_feeder

Upstream control and skew stage for the N×N systolic matrix multiplier. It takes a start pulse and then a valid/ready stream of row vectors. The first N beats load weights through the processing-element daisy chain using load_en and the per-column weight inputs. Every later beat is an activation vector, which the block skews so that array row r receives its element r cycles after row 0. Outputs feed the top-row weight_in ports and the left-column data_in ports of the array directly.

## Interface
- DATA_WIDTH, 16, signed element width (matches PE DATA_WIDTH)
- N, 2, array dimension (rows = columns), ≥2
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  begin a job; sampled only in IDLE
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid && in_ready
- in_data  in  N*DATA_WIDTH  lane r = bits [r*DATA_WIDTH +: DATA_WIDTH]
- in_last  in  1  marks final activation beat; sampled only in STREAM
- load_en  out  1  to all PEs; high means weight shift
- weight_out  out  N*DATA_WIDTH  lane c to top PE of column c
- data_out  out  N*DATA_WIDTH  lane r to left PE of row r
- data_valid  out  N  per-row lane valid (for downstream collector)
- busy  out  1  high while not IDLE
- done  out  1  one-cycle pulse at job end
- stat_beats, stat_stalls  out  16 each  statistics (see Configuration)

## Operation
- FSM states: IDLE, LOAD, STREAM, DRAIN.
- IDLE: in_ready=0. start=1 → LOAD with weight counter cleared.
- LOAD: in_ready=1. Each accepted beat registers in_data onto weight_out, drives load_en=1 for the next cycle, and increments the counter. Beat k carries weights for array row N-1-k, bottom row first, because the chain shifts downward. After N accepted beats → STREAM. in_last is ignored in LOAD.
- Load bubble: if no beat is accepted, next-cycle load_en=0 and weight_out=0. The chain holds.
- STREAM: in_ready=1. An accepted beat enters skew line r at depth r. If in_last is set on an accepted beat → DRAIN.
- STREAM bubble (in_valid=0): zeros enter the skew lines with valid=0. There is no downstream backpressure.
- DRAIN: in_ready=0. Zeros with valid=0 are shifted in for N cycles. The final cycle registers done=1 for the next cycle, and the state → IDLE.
- Skew line r: r+1 register stages, holding data and a valid bit. data_out lane r and data_valid[r] are its last stage.
- Values pass through unmodified. There is no arithmetic or width change.
- start outside IDLE is ignored. start and in_valid together in IDLE: only start acts, no beat is accepted.

## Timing
- Reset values: state IDLE; in_ready, load_en, busy, done = 0; weight_out, data_out, data_valid, all skew registers, counters = 0.
- Reset mid-operation clears everything immediately. Partially loaded weights in the PEs are not the feeder's concern.
- Weight beat accepted at edge t → load_en=1 and weight_out valid during cycle t+1.
- Activation accepted at edge t → lane r valid during cycle t+1+r.
- Last activation accepted at edge t → data_valid[N-1] high in cycle t+N, done high in cycle t+N+1, busy low from cycle t+N+2.
- busy rises in the cycle after start is sampled and stays high through the done cycle.
- in_ready is combinational from state only, never from in_valid.

## Configuration
- SYSTOLIC_FEEDER_STATS_EN defined:
  - stat_beats counts accepted beats (LOAD and STREAM).
  - stat_stalls counts STREAM cycles with in_valid=0.
  - Both counters are 16-bit, saturate at 0xFFFF, and clear on reset and on start acceptance.
- Not defined: stat_beats and stat_stalls are tied to 0 and no counter logic is built.

## Test plan
- Reset: hold rst_n=0 for 3 cycles with start=1 → all outputs 0, in_ready=0; release → IDLE, busy=0.
- Weight load, N=2: start, then beats lanes {3,4} and {1,2} back-to-back → load_en high for 2 consecutive cycles with weight_out {3,4} then {1,2}; state → STREAM.
- Skewed stream: after load, send {5,6} then {7,8} with in_last → row0 shows 5, 7 in cycles t+1, t+2; row1 shows 6, 8 in t+2, t+3; data_valid matches; done in t+4.
- Bubbles: in_valid low for 1 cycle between weight beats and between activations → load_en has a 0 gap with chain held; a zero valid=0 slot is inserted in both skew lanes, shifted by row.
- Mid-job reset: assert rst_n=0 during STREAM with lane data in flight → data_out and data_valid clear asynchronously; after release, a new start works normally.
- Stats (macro on): 2 weight beats, 3 activations, 2 stall cycles → stat_beats=5, stat_stalls=2. Macro off → both 0.

Source files
------------

// File: rtl/systolic_input_feeder.sv
// Weight-load and activation-skew front end for an N x N systolic array.
// Optional statistics counters are built only when SYSTOLIC_FEEDER_STATS_EN is defined.
module systolic_input_feeder #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned N          = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [N*DATA_WIDTH-1:0]   in_data,
    input  logic                      in_last,
    output logic                      load_en,
    output logic [N*DATA_WIDTH-1:0]   weight_out,
    output logic [N*DATA_WIDTH-1:0]   data_out,
    output logic [N-1:0]              data_valid,
    output logic                      busy,
    output logic                      done,
    output logic [15:0]               stat_beats,
    output logic [15:0]               stat_stalls
);

    localparam int unsigned BUS_W  = N * DATA_WIDTH;
    localparam int unsigned CNT_W  = $clog2(N) + 1;
    localparam int unsigned STAT_W = 16;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LOAD   = 2'd1;
    localparam logic [1:0] S_STREAM = 2'd2;
    localparam logic [1:0] S_DRAIN  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             load_en_q, load_en_d;
    logic [BUS_W-1:0] weight_q, weight_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             accept;
    logic             stream_beat;

    // Ready depends on state alone so upstream never sees a valid->ready path
    assign in_ready    = (state_q == S_LOAD) || (state_q == S_STREAM);
    assign accept      = in_valid && in_ready;
    assign stream_beat = accept && (state_q == S_STREAM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            load_en_q <= 1'b0;
            weight_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            load_en_q <= load_en_d;
            weight_q  <= weight_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // cnt counts weight beats in LOAD and flush cycles in DRAIN
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        load_en_d = 1'b0;
        weight_d  = '0;
        done_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                    cnt_d   = '0;
                end
            end
            S_LOAD: begin
                if (accept) begin
                    load_en_d = 1'b1;
                    weight_d  = in_data;
                    cnt_d     = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(N - 1)) begin
                        state_d = S_STREAM;
                        cnt_d   = '0;
                    end
                end
            end
            S_STREAM: begin
                if (accept && in_last) begin
                    state_d = S_DRAIN;
                    cnt_d   = '0;
                end
            end
            S_DRAIN: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(N - 1)) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
        busy_d = (state_d != S_IDLE) || done_d;
    end

    assign load_en    = load_en_q;
    assign weight_out = weight_q;
    assign busy       = busy_q;
    assign done       = done_q;

    // Row r delays its lane by r extra stages; lines shift every cycle, zeros when no beat
    for (genvar r = 0; r < N; r++) begin : g_row
        logic [DATA_WIDTH-1:0] d_q [0:r];
        logic [r:0]            v_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int s = 0; s <= r; s++) begin
                    d_q[s] <= '0;
                end
                v_q <= '0;
            end else begin
                d_q[0] <= stream_beat ? in_data[r*DATA_WIDTH +: DATA_WIDTH] : '0;
                v_q[0] <= stream_beat;
                for (int s = 1; s <= r; s++) begin
                    d_q[s] <= d_q[s-1];
                    v_q[s] <= v_q[s-1];
                end
            end
        end

        assign data_out[r*DATA_WIDTH +: DATA_WIDTH] = d_q[r];
        assign data_valid[r]                        = v_q[r];
    end

`ifdef SYSTOLIC_FEEDER_STATS_EN
    logic [STAT_W-1:0] beats_q, beats_d;
    logic [STAT_W-1:0] stalls_q, stalls_d;

    // Saturating job statistics, cleared when a new job is accepted
    always_comb begin
        beats_d  = beats_q;
        stalls_d = stalls_q;
        if ((state_q == S_IDLE) && start) begin
            beats_d  = '0;
            stalls_d = '0;
        end else begin
            if (accept && (beats_q != {STAT_W{1'b1}})) begin
                beats_d = beats_q + STAT_W'(1);
            end
            if ((state_q == S_STREAM) && !in_valid && (stalls_q != {STAT_W{1'b1}})) begin
                stalls_d = stalls_q + STAT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beats_q  <= '0;
            stalls_q <= '0;
        end else begin
            beats_q  <= beats_d;
            stalls_q <= stalls_d;
        end
    end

    assign stat_beats  = beats_q;
    assign stat_stalls = stalls_q;
`else
    assign stat_beats  = '0;
    assign stat_stalls = '0;
`endif

endmodule

// File: tb/tb_systolic_input_feeder.sv
// Directed bench for systolic_input_feeder (N=2, 16-bit lanes).
module tb_systolic_input_feeder;

    localparam int unsigned DW = 16;
    localparam int unsigned NN = 2;

    logic            clk;
    logic            rst_n;
    logic            start;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_data;
    logic            in_last;
    logic            load_en;
    logic [31:0]     weight_out;
    logic [31:0]     data_out;
    logic [1:0]      data_valid;
    logic            busy;
    logic            done;
    logic [15:0]     stat_beats;
    logic [15:0]     stat_stalls;

    int checks = 0;
    int errors = 0;

    systolic_input_feeder #(.DATA_WIDTH(DW), .N(NN)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .load_en    (load_en),
        .weight_out (weight_out),
        .data_out   (data_out),
        .data_valid (data_valid),
        .busy       (busy),
        .done       (done),
        .stat_beats (stat_beats),
        .stat_stalls(stat_stalls)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_stats(input string tag, input logic [15:0] beats, input logic [15:0] stalls);
`ifdef SYSTOLIC_FEEDER_STATS_EN
        chk({tag, "_beats"}, 32'(stat_beats), 32'(beats));
        chk({tag, "_stalls"}, 32'(stat_stalls), 32'(stalls));
`else
        chk({tag, "_beats_off"}, 32'(stat_beats), 32'd0);
        chk({tag, "_stalls_off"}, 32'(stat_stalls), 32'd0);
        if (beats == 16'hFFFF && stalls == 16'hFFFF) $display("note: unreachable stats pair");
`endif
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        in_last  = 1'b0;

        // Reset held 3 cycles with start asserted
        tick(); tick(); tick();
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_load_en", 32'(load_en), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_weight", weight_out, 32'd0);
        chk("rst_data", data_out, 32'd0);
        chk("rst_valid", 32'(data_valid), 32'd0);
        chk_stats("rst", 16'd0, 16'd0);
        rst_n = 1'b1;
        start = 1'b0;
        tick();
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_ready", 32'(in_ready), 32'd0);

        // Job 1: start together with in_valid -> only start acts
        start = 1'b1; in_valid = 1'b1; in_data = 32'h0004_0003;
        tick();
        chk("j1_busy", 32'(busy), 32'd1);
        chk("j1_ready_load", 32'(in_ready), 32'd1);
        chk("j1_no_load_yet", 32'(load_en), 32'd0);
        start = 1'b0;
        tick();
        chk("j1_w0_en", 32'(load_en), 32'd1);
        chk("j1_w0", weight_out, 32'h0004_0003);
        in_data = 32'h0002_0001;
        tick();
        chk("j1_w1_en", 32'(load_en), 32'd1);
        chk("j1_w1", weight_out, 32'h0002_0001);
        in_valid = 1'b0;
        tick();
        chk("j1_post_load_en", 32'(load_en), 32'd0);
        chk("j1_post_load_w", weight_out, 32'd0);
        chk("j1_stream_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1; in_data = 32'h0006_0005;
        tick();
        chk("j1_a_t1_data", data_out, 32'h0000_0005);
        chk("j1_a_t1_valid", 32'(data_valid), 32'b01);
        in_data = 32'h0008_0007; in_last = 1'b1;
        tick();
        chk("j1_a_t2_data", data_out, 32'h0006_0007);
        chk("j1_a_t2_valid", 32'(data_valid), 32'b11);
        in_valid = 1'b0; in_last = 1'b0;
        tick();
        chk("j1_a_t3_data", data_out, 32'h0008_0000);
        chk("j1_a_t3_valid", 32'(data_valid), 32'b10);
        chk("j1_drain_ready", 32'(in_ready), 32'd0);
        chk("j1_t3_done", 32'(done), 32'd0);
        tick();
        chk("j1_done", 32'(done), 32'd1);
        chk("j1_done_busy", 32'(busy), 32'd1);
        chk("j1_done_valid", 32'(data_valid), 32'b00);
        chk_stats("j1", 16'd4, 16'd1);
        tick();
        chk("j1_after_done", 32'(done), 32'd0);
        chk("j1_after_busy", 32'(busy), 32'd0);

        // Job 2: bubbles in load and stream
        start = 1'b1;
        tick();
        chk_stats("j2_cleared", 16'd0, 16'd0);
        start = 1'b0; in_valid = 1'b1; in_data = 32'h000B_000A;
        tick();
        chk("j2_w0", weight_out, 32'h000B_000A);
        chk("j2_w0_en", 32'(load_en), 32'd1);
        in_valid = 1'b0;
        tick();
        chk("j2_gap_en", 32'(load_en), 32'd0);
        chk("j2_gap_w", weight_out, 32'd0);
        chk("j2_gap_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1; in_data = 32'h000D_000C;
        tick();
        chk("j2_w1", weight_out, 32'h000D_000C);
        chk("j2_w1_en", 32'(load_en), 32'd1);
        in_data = 32'h0015_0014;
        tick();
        chk("j2_a0", data_out, 32'h0000_0014);
        chk("j2_a0_v", 32'(data_valid), 32'b01);
        in_valid = 1'b0;
        tick();
        chk("j2_s0", data_out, 32'h0015_0000);
        chk("j2_s0_v", 32'(data_valid), 32'b10);
        in_valid = 1'b1; in_data = 32'h0017_0016;
        tick();
        chk("j2_a1", data_out, 32'h0000_0016);
        chk("j2_a1_v", 32'(data_valid), 32'b01);
        in_valid = 1'b0;
        tick();
        chk("j2_s1", data_out, 32'h0017_0000);
        chk("j2_s1_v", 32'(data_valid), 32'b10);
        in_valid = 1'b1; in_data = 32'h0019_0018; in_last = 1'b1;
        tick();
        chk("j2_a2", data_out, 32'h0000_0018);
        chk("j2_a2_v", 32'(data_valid), 32'b01);
        in_valid = 1'b0; in_last = 1'b0;
        tick();
        chk("j2_a2_row1", data_out, 32'h0019_0000);
        chk("j2_a2_row1_v", 32'(data_valid), 32'b10);
        chk("j2_not_done", 32'(done), 32'd0);
        tick();
        chk("j2_done", 32'(done), 32'd1);
        chk_stats("j2", 16'd5, 16'd2);
        tick();
        chk("j2_idle_busy", 32'(busy), 32'd0);

        // Job 3: asynchronous reset with lane data in flight
        start = 1'b1;
        tick();
        start = 1'b0; in_valid = 1'b1; in_data = 32'h0001_0001;
        tick(); tick();
        in_data = 32'h001F_001E;
        tick();
        chk("j3_inflight", data_out, 32'h0000_001E);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("j3_arst_data", data_out, 32'd0);
        chk("j3_arst_valid", 32'(data_valid), 32'd0);
        chk("j3_arst_busy", 32'(busy), 32'd0);
        chk("j3_arst_ready", 32'(in_ready), 32'd0);
        chk_stats("j3_arst", 16'd0, 16'd0);
        tick();
        rst_n = 1'b1;
        tick();
        start = 1'b1;
        tick();
        chk("j4_busy", 32'(busy), 32'd1);
        chk("j4_ready", 32'(in_ready), 32'd1);
        start = 1'b0; in_valid = 1'b1; in_data = 32'h0029_0028;
        tick();
        chk("j4_w0", weight_out, 32'h0029_0028);
        chk("j4_w0_en", 32'(load_en), 32'd1);
        chk_stats("j4", 16'd1, 16'd0);
        in_valid = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
